// File: rtl/mfp_ahb_lite_srec_dumper.sv
// mfp_ahb_lite_srec_dumper: AHB-Lite reader that streams a memory region as S3/S7 S-records; MFP_SREC_DUMPER_S0_HEADER_EN adds a leading S0 header
module mfp_ahb_lite_srec_dumper #(
    parameter int BYTES_PER_RECORD = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        big_endian,
    input  logic        start,
    input  logic [31:0] start_address,
    input  logic [15:0] byte_count,
    output logic        busy,
    output logic        done,
    output logic        bus_error,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready
);
    localparam int BW = $clog2(8 * BYTES_PER_RECORD);
`ifdef MFP_SREC_DUMPER_S0_HEADER_EN
    localparam logic [95:0] HDR_STR = "S0030000FC\r\n";
`endif
    typedef enum logic [2:0] {
        IDLE,
`ifdef MFP_SREC_DUMPER_S0_HEADER_EN
        HDR,
`endif
        FETCH_A,
        FETCH_D,
        EMIT,
        TERM,
        FIN
    } state_t;
    state_t state, state_next;
    logic [31:0] addr, base, rec_addr;
    logic [15:0] remaining;
    logic        big;
    logic [8*BYTES_PER_RECORD-1:0] buff;
    logic [3:0]  wi, words, nib;
    logic [7:0]  ci, sum, last, k, fv, hx, seq;
    logic [6:0]  n, f;
    logic        accept, at_last;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign HSIZE     = 3'b010;
    assign HWDATA    = 32'h0;
    assign HWRITE    = 1'b0;
    assign HADDR     = addr;
    assign HTRANS    = state == FETCH_A ? 2'b10 : 2'b00;
    assign busy      = state != IDLE && state != FIN;
    assign done      = state == FIN;
    assign n         = remaining < 16'(BYTES_PER_RECORD) ? remaining[6:0] : 7'(BYTES_PER_RECORD);
    assign words     = 4'((n + 7'd3) >> 2);
    assign accept    = char_valid && char_ready;
    assign at_last   = accept && ci == last;
    // character generator: record shape is S,type,hex fields (LEN, 4 address bytes, data, CK),CR,LF
    always_comb begin
        k   = ci - 8'd2;
        f   = k[7:1];
        fv  = f == 7'd0 ? 8'(n + 7'd5) : f < 7'd5 ? rec_addr[5'(8 * (4 - f)) +: 8] :
              f < n + 7'd5 ? buff[BW'(8 * (f - 7'd5)) +: 8] : ~sum;
        nib = k[0] ? fv[3:0] : fv[7:4];
        hx  = nib < 4'd10 ? 8'h30 + {4'd0, nib} : 8'h37 + {4'd0, nib};
        last = {n, 1'b0} + 8'd15;
        seq = ci == 8'd0 ? 8'h53 : ci == 8'd1 ? (state == TERM ? 8'h37 : 8'h33) :
              ci < last - 8'd1 ? hx : ci == last - 8'd1 ? 8'h0D : 8'h0A;
        char_valid = state == EMIT || state == TERM;
        char_data  = char_valid ? seq : 8'h00;
`ifdef MFP_SREC_DUMPER_S0_HEADER_EN
        if (state == HDR) begin
            last       = 8'd11;
            char_valid = 1'b1;
            char_data  = HDR_STR[7'(8 * (11 - ci)) +: 8];
        end
`endif
    end
    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end
    // next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:
`ifdef MFP_SREC_DUMPER_S0_HEADER_EN
                if (start) state_next = HDR;
            HDR:     if (at_last) state_next = remaining == 16'd0 ? TERM : FETCH_A;
`else
                if (start) state_next = byte_count == 16'd0 ? TERM : FETCH_A;
`endif
            FETCH_A: if (HREADY) state_next = FETCH_D;
            FETCH_D: state_next = HRESP ? FIN : !HREADY ? FETCH_D : wi + 4'd1 == words ? EMIT : FETCH_A;
            EMIT:    if (at_last) state_next = remaining == 16'(n) ? TERM : FETCH_A;
            TERM:    if (at_last) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    // datapath: address/count tracking, record buffer fill, character counter and checksum
    always_ff @(posedge clock) begin
        if (reset) begin
            addr      <= 32'h0;
            base      <= 32'h0;
            rec_addr  <= 32'h0;
            remaining <= 16'h0;
            big       <= 1'b0;
            buff      <= '0;
            wi        <= 4'd0;
            ci        <= 8'd0;
            sum       <= 8'd0;
            bus_error <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                addr      <= start_address;
                base      <= start_address;
                rec_addr  <= start_address;
                remaining <= byte_count;
                big       <= big_endian;
                wi        <= 4'd0;
                ci        <= 8'd0;
                sum       <= 8'd0;
                bus_error <= 1'b0;
            end
            if (state == FETCH_D && HRESP) bus_error <= 1'b1;
            else if (state == FETCH_D && HREADY) begin
                buff[BW'(32 * wi) +: 32] <= big ? {HRDATA[7:0], HRDATA[15:8], HRDATA[23:16], HRDATA[31:24]} : HRDATA;
                addr <= addr + 32'd4;
                wi   <= wi + 4'd1;
            end
            if (accept) begin
                ci  <= at_last ? 8'd0 : ci + 8'd1;
                sum <= at_last ? 8'd0 : (k[0] && f < n + 7'd5) ? sum + fv : sum;
            end
            if (state == EMIT && at_last) begin
                remaining <= remaining - 16'(n);
                rec_addr  <= remaining == 16'(n) ? base : rec_addr + 32'(n);
                wi        <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_mfp_ahb_lite_srec_dumper.sv
// tb_mfp_ahb_lite_srec_dumper: directed S-record dump checks against hand-computed records
module tb_mfp_ahb_lite_srec_dumper;
    logic        clock = 0, reset = 1, big_endian = 0, start = 0;
    logic [31:0] start_address = 0;
    logic [15:0] byte_count = 0;
    logic        busy, done, bus_error;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HBURST, HSIZE;
    logic        HMASTLOCK, HWRITE, HREADY, HRESP;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [7:0]  char_data;
    logic        char_valid, char_ready;
    logic        hready = 1, cready = 1, err_en = 0;
    logic [31:0] err_addr = 0;
    logic        dphase;
    logic [31:0] daddr;
    logic [31:0] mem [16];
    byte unsigned rx[$];
    int          nonseq, total = 0, bad = 0;
    logic        err_seen;
    string       s;

    mfp_ahb_lite_srec_dumper dut (
        .clock(clock), .reset(reset), .big_endian(big_endian), .start(start),
        .start_address(start_address), .byte_count(byte_count),
        .busy(busy), .done(done), .bus_error(bus_error),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready)
    );

    always #5 clock = ~clock;

    assign HREADY     = hready;
    assign char_ready = cready;
    assign HRDATA     = dphase ? mem[daddr[5:2]] : 32'h0;
    assign HRESP      = dphase && err_en && daddr == err_addr;

    always @(posedge clock) begin
        if (reset) dphase <= 1'b0;
        else if (HREADY) begin
            dphase <= HTRANS == 2'b10;
            daddr  <= HADDR;
        end
    end

    always @(posedge clock) begin
        if (char_valid && char_ready) rx.push_back(char_data);
        if (HTRANS == 2'b10 && HREADY) nonseq++;
    end

    task automatic chk(input string tag, input string got, input string exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got '%s' expected '%s'", tag, got, exp);
        end
    endtask

    function automatic string vis(input string t);
        string r = "";
        for (int i = 0; i < t.len(); i++)
            r = t[i] == 8'h0D ? {r, "\\r"} : t[i] == 8'h0A ? {r, "\\n"} : $sformatf("%s%c", r, t[i]);
        return r;
    endfunction

    task automatic dump(input logic [31:0] a, input logic [15:0] c, input logic be, output string got);
        int i;
        rx.delete();
        nonseq = 0;
        @(negedge clock);
        start_address = a;
        byte_count    = c;
        big_endian    = be;
        start         = 1;
        @(negedge clock);
        start = 0;
        chk("busy_after_start", $sformatf("%0d", busy), "1");
        i = 0;
        while (!done && i < 3000) begin
            @(negedge clock);
            i++;
        end
        chk("done_seen", $sformatf("%0d", done), "1");
        chk("busy_at_done", $sformatf("%0d", busy), "0");
        err_seen = bus_error;
        @(negedge clock);
        chk("done_one_cycle", $sformatf("%0d", done), "0");
        got = "";
        foreach (rx[j]) got = $sformatf("%s%c", got, rx[j]);
        got = vis(got);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 32'h0;
        mem[4] = 32'h44332211;
        mem[5] = 32'h88776655;
        mem[6] = 32'hCCBBAA99;
        mem[7] = 32'h00FFEEDD;
        mem[8] = 32'h04030201;
        repeat (3) @(negedge clock);
        chk("rst_busy", $sformatf("%0d", busy), "0");
        chk("rst_done", $sformatf("%0d", done), "0");
        chk("rst_bus_error", $sformatf("%0d", bus_error), "0");
        chk("rst_htrans", $sformatf("%0d", HTRANS), "0");
        chk("rst_haddr", $sformatf("%0h", HADDR), "0");
        chk("rst_char_valid", $sformatf("%0d", char_valid), "0");
        chk("rst_char_data", $sformatf("%0h", char_data), "0");
        reset = 0;

        dump(32'h10, 16'd4, 1'b0, s);
        chk("le4_text", s, vis("S30900000010112233443C\r\nS70500000010EA\r\n"));
        chk("le4_reads", $sformatf("%0d", nonseq), "1");
        chk("le4_bus_error", $sformatf("%0d", err_seen), "0");

        dump(32'h10, 16'd4, 1'b1, s);
        chk("be4_text", s, vis("S30900000010443322113C\r\nS70500000010EA\r\n"));

        dump(32'h10, 16'd6, 1'b0, s);
        chk("le6_text", s, vis("S30B000000101122334455667F\r\nS70500000010EA\r\n"));
        chk("le6_reads", $sformatf("%0d", nonseq), "2");

        dump(32'h0, 16'd0, 1'b0, s);
        chk("cnt0_text", s, vis("S70500000000FA\r\n"));
        chk("cnt0_reads", $sformatf("%0d", nonseq), "0");

        fork
            dump(32'h10, 16'd20, 1'b0, s);
            begin
                int w = 0;
                while (HTRANS != 2'b10 && w < 100) begin
                    @(negedge clock);
                    w++;
                end
                hready = 0;
                repeat (3) begin
                    @(negedge clock);
                    chk("stall_htrans", $sformatf("%0d", HTRANS), "2");
                    chk("stall_haddr", $sformatf("%0h", HADDR), "10");
                end
                hready = 1;
            end
        join
        chk("c20_text", s, vis({"S315000000101122334455667788", "99AABBCCDDEEFF00E2\r\n",
                                "S3090000002001020304CC\r\nS70500000010EA\r\n"}));
        chk("c20_reads", $sformatf("%0d", nonseq), "5");

        err_en   = 1;
        err_addr = 32'h14;
        dump(32'h10, 16'd8, 1'b0, s);
        chk("err_text", s, "");
        chk("err_bus_error", $sformatf("%0d", err_seen), "1");
        chk("err_reads", $sformatf("%0d", nonseq), "2");
        err_en = 0;

        fork
            dump(32'h10, 16'd4, 1'b0, s);
            begin
                int w = 0;
                logic [7:0] held;
                logic stable = 1;
                while (rx.size() < 5 && w < 200) begin
                    @(negedge clock);
                    w++;
                end
                cready = 0;
                held = char_data;
                repeat (10) begin
                    @(negedge clock);
                    if (char_data != held || !char_valid) stable = 0;
                end
                chk("stall_char_stable", $sformatf("%0d", stable), "1");
                cready = 1;
            end
        join
        chk("stall_text", s, vis("S30900000010112233443C\r\nS70500000010EA\r\n"));
        chk("bus_error_cleared", $sformatf("%0d", err_seen), "0");

        begin
            int w = 0;
            @(negedge clock);
            start_address = 32'h10;
            byte_count    = 16'd20;
            start         = 1;
            @(negedge clock);
            start = 0;
            rx.delete();
            while (rx.size() < 10 && w < 500) begin
                @(negedge clock);
                w++;
            end
            chk("mid_emit_reached", $sformatf("%0d", char_valid), "1");
            reset = 1;
            @(negedge clock);
            chk("mid_rst_busy", $sformatf("%0d", busy), "0");
            chk("mid_rst_char_valid", $sformatf("%0d", char_valid), "0");
            chk("mid_rst_htrans", $sformatf("%0d", HTRANS), "0");
            reset = 0;
        end
        dump(32'h10, 16'd4, 1'b0, s);
        chk("after_rst_text", s, vis("S30900000010112233443C\r\nS70500000010EA\r\n"));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
